semiauto_cmd_latch: RTL and testbench
=====================================

// Module: semiauto_cmd_latch
// PURPOSE
//  Upstream command stage for the semi-auto driving FSM. Synchronises and debounces the
//  four raw direction buttons, then latches one direction command. The command is held as
//  a level on left/right/straight/back until the semi-auto FSM has fully executed it
//  (waiting -> turning/cooldown -> move forward), so the U-turn (back) level stays valid
//  throughout the turn. The outputs feed the semi-auto FSM direction inputs directly.
// PARAMETERS
//  DEBOUNCE_CYCLES  2_000_000  consecutive stable sys_clk samples required to accept a level change (20 ms @ 100 MHz)
//  CNT_W            21         debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  sys_clk        in   1  system clock; the only clock in this block
//  rst            in   1  synchronous, active-high reset
//  power          in   1  car power; 0 = block disabled
//  global_state   in   2  top-level mode; 2'b10 = semi-auto; any other value = block disabled
//  state          in   2  semi-auto FSM current state: 01 fwd, 00 wait, 10 turn, 11 cooldown
//  btn_left       in   1  raw left button, asynchronous, bouncy
//  btn_right      in   1  raw right button
//  btn_straight   in   1  raw straight button
//  btn_back       in   1  raw back (U-turn) button
//  left           out  1  latched command: turn left
//  right          out  1  latched command: turn right
//  straight       out  1  latched command: go straight
//  back           out  1  latched command: U-turn
//  cmd_pending    out  1  command latched, not yet taken (HOLD state)
//  cmd_active     out  1  command being executed (ACTIVE state)
// BEHAVIOUR
//  - Reset: every output is 0; sync flops, debounced levels and counters are 0; FSM is IDLE.
//  - Sync: each button passes through a 2-flop synchroniser (sync1 -> sync2).
//  - Debounce, per button:
//    - if sync2 == deb, cnt <= 0;
//    - else if cnt == DEBOUNCE_CYCLES-1, deb <= sync2 and cnt <= 0;
//    - else cnt <= cnt + 1.
//    - A level change is therefore accepted after DEBOUNCE_CYCLES consecutive differing samples.
//    - Any bounce restarts the count. The counter never wraps.
//  - Press pulse: press = deb & ~deb_d, one cycle per accepted rising edge. Releases produce no event.
//  - Enable: en = power & (global_state == 2'b10).
//    - en = 0 forces FSM to IDLE with all command outputs 0 on the next edge.
//    - Debounce keeps running while disabled.
//  - Command FSM, all outputs registered:
//    - IDLE: outputs 0. On any press with en = 1, go to HOLD and set exactly one command.
//      Priority for same-cycle presses: straight > back > left > right.
//    - HOLD: cmd_pending = 1.
//      - A new press replaces the held command, same priority, one-hot kept.
//      - state == 10 or 11 -> ACTIVE, command unchanged.
//      - state == 01 or 00 -> stay in HOLD.
//    - ACTIVE: cmd_active = 1. Presses are ignored.
//      - state == 01 -> IDLE, all command outputs cleared on that edge.
//      - Otherwise stay in ACTIVE.
//  - Latency: press pulse at edge N -> command output and cmd_pending high after edge N+1.
//    Raw edge to output = 2 sync + DEBOUNCE_CYCLES + 2 cycles.
//  - Invariants:
//    - At most one of left/right/straight/back is high.
//    - Any command high implies cmd_pending ^ cmd_active.
//  - rst mid-HOLD/ACTIVE: everything returns to reset values on that edge.
//    A button still held after rst must be re-debounced and yields a new press.
// TESTING (DEBOUNCE_CYCLES=4)
//  1. btn_left 0->1 stable, en=1, state=00
//     -> left=1, cmd_pending=1 exactly 2+4+2 = 8 cycles after the raw edge; other outputs 0.
//  2. btn_right toggling every 2 cycles for 20 cycles, then low
//     -> deb never rises; all outputs stay 0.
//  3. btn_back and btn_straight rise in the same cycle
//     -> straight=1, back=0. Repeat with back+left -> back=1.
//  4. Hold left, state 00->10->11->01
//     -> cmd_active=1 from the first 10 sample; left held through 10 and 11;
//        left=0 and IDLE one edge after state=01.
//  5. In HOLD with left, press right
//     -> right=1, left=0. In ACTIVE, press straight -> ignored, right stays 1.
//  6. ACTIVE with back=1: drop power (then separately assert rst)
//     -> all outputs 0 next edge; a new press is accepted only after re-enable.

Source files
------------

// File: rtl/semiauto_cmd_latch_if.sv
`default_nettype none
// ============================================================================
// Module      : semiauto_cmd_latch_if
// Description : Button, mode and latched-command signals of the semi-auto
//               command latch. The master drives buttons and mode; the slave
//               returns the latched direction command.
// Revision    : 1.0 - initial release
// ============================================================================
interface semiauto_cmd_latch_if;
   logic       power;
   logic [1:0] global_state;
   logic [1:0] state;
   logic       btn_left;
   logic       btn_right;
   logic       btn_straight;
   logic       btn_back;
   logic       left;
   logic       right;
   logic       straight;
   logic       back;
   logic       cmd_pending;
   logic       cmd_active;

   modport master (
      output power, global_state, state,
      output btn_left, btn_right, btn_straight, btn_back,
      input  left, right, straight, back, cmd_pending, cmd_active
   );

   modport slave (
      input  power, global_state, state,
      input  btn_left, btn_right, btn_straight, btn_back,
      output left, right, straight, back, cmd_pending, cmd_active
   );
endinterface
`default_nettype wire

// File: rtl/semiauto_cmd_latch.sv
`default_nettype none
// ============================================================================
// Module      : semiauto_cmd_latch
// Description : Synchronises and debounces four direction buttons and latches
//               one command until the semi-auto FSM has executed it.
// Revision    : 1.0 - initial release
// ============================================================================
module semiauto_cmd_latch #(
   parameter int DEBOUNCE_CYCLES = 2_000_000,
   parameter int CNT_W           = 21
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   semiauto_cmd_latch_if.slave  bus
);

   localparam logic [CNT_W-1:0] c_deb_max = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_ACTIVE = 2'd2
   } fsm_t;

   // Bit order everywhere: 0 left, 1 right, 2 straight, 3 back.
   logic [3:0] w_raw;
   logic [3:0] w_deb;
   logic [3:0] w_sel;
   logic       w_en;

   logic [3:0] r_deb_d;
   logic [3:0] r_press;
   logic [3:0] r_cmd;
   logic       r_pending;
   logic       r_active;
   fsm_t       r_fsm;

   assign w_raw = {bus.btn_back, bus.btn_straight, bus.btn_right, bus.btn_left};
   assign w_en  = bus.power & (bus.global_state == 2'b10);

   generate
      for (genvar i = 0; i < 4; i++) begin : g_btn
         logic             r_sync1;
         logic             r_sync2;
         logic             r_deb;
         logic [CNT_W-1:0] r_cnt;

         always_ff @(posedge sys_clk) begin
            if (rst) begin
               r_sync1 <= 1'b0;
               r_sync2 <= 1'b0;
               r_deb   <= 1'b0;
               r_cnt   <= '0;
            end else begin
               r_sync1 <= w_raw[i];
               r_sync2 <= r_sync1;
               if (r_sync2 == r_deb) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_deb_max) begin
                  r_deb <= r_sync2;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         end

         assign w_deb[i] = r_deb;
      end
   endgenerate

   // Same-cycle presses resolve as straight > back > left > right.
   always_comb begin
      w_sel = 4'b0000;
      if (r_press[2])      w_sel[2] = 1'b1;
      else if (r_press[3]) w_sel[3] = 1'b1;
      else if (r_press[0]) w_sel[0] = 1'b1;
      else if (r_press[1]) w_sel[1] = 1'b1;
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_deb_d   <= 4'b0000;
         r_press   <= 4'b0000;
         r_cmd     <= 4'b0000;
         r_pending <= 1'b0;
         r_active  <= 1'b0;
         r_fsm     <= ST_IDLE;
      end else begin
         r_deb_d <= w_deb;
         r_press <= w_deb & ~r_deb_d;
         if (!w_en) begin
            r_fsm     <= ST_IDLE;
            r_cmd     <= 4'b0000;
            r_pending <= 1'b0;
            r_active  <= 1'b0;
         end else begin
            case (r_fsm)
               ST_IDLE: begin
                  if (|r_press) begin
                     r_fsm     <= ST_HOLD;
                     r_cmd     <= w_sel;
                     r_pending <= 1'b1;
                  end
               end
               ST_HOLD: begin
                  if (|r_press) r_cmd <= w_sel;
                  // Turn or cooldown means the FSM has taken the command.
                  if (bus.state[1]) begin
                     r_fsm     <= ST_ACTIVE;
                     r_pending <= 1'b0;
                     r_active  <= 1'b1;
                  end
               end
               ST_ACTIVE: begin
                  if (bus.state == 2'b01) begin
                     r_fsm    <= ST_IDLE;
                     r_cmd    <= 4'b0000;
                     r_active <= 1'b0;
                  end
               end
               default: begin
                  r_fsm     <= ST_IDLE;
                  r_cmd     <= 4'b0000;
                  r_pending <= 1'b0;
                  r_active  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.left        = r_cmd[0];
   assign bus.right       = r_cmd[1];
   assign bus.straight    = r_cmd[2];
   assign bus.back        = r_cmd[3];
   assign bus.cmd_pending = r_pending;
   assign bus.cmd_active  = r_active;

endmodule
`default_nettype wire

// File: tb/tb_semiauto_cmd_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_semiauto_cmd_latch
// Description : Self-checking bench for semiauto_cmd_latch with a short
//               debounce window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_semiauto_cmd_latch;

   logic sys_clk = 1'b0;
   logic rst     = 1'b1;

   semiauto_cmd_latch_if bus ();

   semiauto_cmd_latch #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3)
   ) dut (
      .sys_clk (sys_clk),
      .rst     (rst),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   // {left, right, straight, back, cmd_pending, cmd_active}
   logic [5:0] w_outs;
   assign w_outs = {bus.left, bus.right, bus.straight, bus.back,
                    bus.cmd_pending, bus.cmd_active};

   // btn bits: 3 back, 2 straight, 1 right, 0 left
   typedef struct {
      string      name;
      logic [3:0] btn;
      logic       pwr;
      logic [1:0] gs;
      logic [1:0] st;
      int         cyc;
      logic [5:0] exp;
   } vec_t;

   typedef struct {
      string      name;
      logic [5:0] exp;
   } sb_t;

   vec_t vecs[$];
   sb_t  sbq[$];
   int   errors = 0;
   int   checks = 0;

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] btn, input logic pwr,
                        input logic [1:0] gs, input logic [1:0] st);
      bus.btn_left     = btn[0];
      bus.btn_right    = btn[1];
      bus.btn_straight = btn[2];
      bus.btn_back     = btn[3];
      bus.power        = pwr;
      bus.global_state = gs;
      bus.state        = st;
   endtask

   task automatic expect_out(input string name, input logic [5:0] exp);
      sb_t e;
      e.name = name;
      e.exp  = exp;
      sbq.push_back(e);
   endtask

   task automatic check_out();
      sb_t e;
      if (sbq.size() == 0) begin
         errors++;
         checks++;
         $display("FAIL scoreboard_empty: got=%b required=an expected entry", w_outs);
      end else begin
         e = sbq.pop_front();
         checks++;
         if (w_outs !== e.exp) begin
            errors++;
            $display("FAIL %s: got=%b required=%b", e.name, w_outs, e.exp);
         end
      end
   endtask

   initial begin
      //                  name            btn      pwr  gs     st     cyc exp
      vecs.push_back('{"hold_release",  4'b0000, 1'b1, 2'b10, 2'b00, 12, 6'b100010});
      vecs.push_back('{"hold_replace",  4'b0010, 1'b1, 2'b10, 2'b00, 12, 6'b010010});
      vecs.push_back('{"take_turn",     4'b0000, 1'b1, 2'b10, 2'b10, 12, 6'b010001});
      vecs.push_back('{"active_ignore", 4'b0100, 1'b1, 2'b10, 2'b11, 12, 6'b010001});
      vecs.push_back('{"done_fwd",      4'b0000, 1'b1, 2'b10, 2'b01, 12, 6'b000000});
      vecs.push_back('{"prio_str_back", 4'b1100, 1'b1, 2'b10, 2'b00, 12, 6'b001010});
      vecs.push_back('{"prio_release",  4'b0000, 1'b1, 2'b10, 2'b00, 12, 6'b001010});
      vecs.push_back('{"prio_back_left",4'b1001, 1'b1, 2'b10, 2'b00, 12, 6'b000110});
      vecs.push_back('{"back_active",   4'b0000, 1'b1, 2'b10, 2'b10, 12, 6'b000101});
      vecs.push_back('{"power_drop",    4'b0000, 1'b0, 2'b10, 2'b10,  1, 6'b000000});
      vecs.push_back('{"press_no_pwr",  4'b0001, 1'b0, 2'b10, 2'b00, 12, 6'b000000});
      vecs.push_back('{"reenable_held", 4'b0001, 1'b1, 2'b10, 2'b00, 12, 6'b000000});
      vecs.push_back('{"release_left",  4'b0000, 1'b1, 2'b10, 2'b00, 12, 6'b000000});
      vecs.push_back('{"press_manual",  4'b0001, 1'b1, 2'b01, 2'b00, 12, 6'b000000});
      vecs.push_back('{"back_to_semi",  4'b0000, 1'b1, 2'b10, 2'b00, 12, 6'b000000});
      vecs.push_back('{"right_hold",    4'b0010, 1'b1, 2'b10, 2'b00, 12, 6'b010010});
      vecs.push_back('{"right_active",  4'b0000, 1'b1, 2'b10, 2'b10, 12, 6'b010001});
      vecs.push_back('{"right_done",    4'b0000, 1'b1, 2'b10, 2'b01,  1, 6'b000000});
      vecs.push_back('{"left_hold",     4'b0001, 1'b1, 2'b10, 2'b00, 12, 6'b100010});
      vecs.push_back('{"left_turn_1st", 4'b0001, 1'b1, 2'b10, 2'b10,  1, 6'b100001});
      vecs.push_back('{"left_cooldown", 4'b0000, 1'b1, 2'b10, 2'b11,  3, 6'b100001});
      vecs.push_back('{"left_fwd_edge", 4'b0000, 1'b1, 2'b10, 2'b01,  1, 6'b000000});
      vecs.push_back('{"idle_quiet",    4'b0000, 1'b1, 2'b10, 2'b00, 12, 6'b000000});
      vecs.push_back('{"back_hold",     4'b1000, 1'b1, 2'b10, 2'b00, 12, 6'b000110});
      vecs.push_back('{"back_turn",     4'b1000, 1'b1, 2'b10, 2'b10,  1, 6'b000101});

      drive(4'b0000, 1'b1, 2'b10, 2'b00);
      rst = 1'b1;
      tick(3);
      expect_out("reset_state", 6'b000000);
      check_out();
      rst = 1'b0;

      // Bouncing right button never settles long enough to register.
      for (int k = 0; k < 10; k++) begin
         bus.btn_right = ~bus.btn_right;
         tick(2);
         expect_out("bounce", 6'b000000);
         check_out();
      end
      tick(8);
      expect_out("bounce_settled", 6'b000000);
      check_out();

      // Raw edge to latched output is exactly 2 + 4 + 2 edges.
      bus.btn_left = 1'b1;
      tick(7);
      expect_out("latency_early", 6'b000000);
      check_out();
      tick(1);
      expect_out("latency_exact", 6'b100010);
      check_out();

      for (int v = 0; v < vecs.size(); v++) begin
         drive(vecs[v].btn, vecs[v].pwr, vecs[v].gs, vecs[v].st);
         expect_out(vecs[v].name, vecs[v].exp);
         tick(vecs[v].cyc);
         check_out();
      end

      // Reset during ACTIVE with back still held: cleared, then re-pressed.
      rst = 1'b1;
      tick(1);
      expect_out("rst_active", 6'b000000);
      check_out();
      rst = 1'b0;
      drive(4'b1000, 1'b1, 2'b10, 2'b00);
      tick(7);
      expect_out("rst_redebounce_early", 6'b000000);
      check_out();
      tick(1);
      expect_out("rst_redebounce", 6'b000110);
      check_out();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
